// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment display controller:
// blank code, hex-to-segment decode table and a counter width helper.
package seg7_pkg;

    // Active-low pattern with every segment off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment pattern for one hex nibble (bit0=a ... bit6=g).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Bits needed to hold the values 0..n-1; never less than one bit.
    function automatic int clog2_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder with a blank override.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] iNIB,
    input  logic       iBLANK,
    output logic [6:0] oSEG
);

    // Blank wins over the decoded pattern.
    always_comb begin
        oSEG = iBLANK ? SEG_BLANK : hex_to_seg(iNIB);
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Hex display controller: shadow-registered digits driving both a static
// per-digit segment bus and a time-multiplexed scan bus with dead time,
// plus leading-zero blanking and per-digit blink.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 12500000
)
(
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic                    iLOAD,
    input  logic [4*NUM_DIGITS-1:0] iDIG,
    input  logic                    iLZB,
    input  logic [NUM_DIGITS-1:0]   iBLINK_MASK,
    output logic [7*NUM_DIGITS-1:0] oSEG,
    output logic [6:0]              oSCAN_SEG,
    output logic [NUM_DIGITS-1:0]   oSCAN_AN,
    output logic                    oLOADED
);

    localparam int IDX_W   = clog2_w(NUM_DIGITS);
    localparam int SCAN_W  = clog2_w(SCAN_DIV);
    localparam int BLINK_W = clog2_w(BLINK_DIV);

    // Shadow copy of the last load.
    logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
    logic                    lzb_q, lzb_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    loaded_q, loaded_d;

    // Scan and blink timing.
    logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
    logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
    logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic                    scan_wrap;
    logic                    blink_wrap;

    // Registered outputs.
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
    logic [6:0]              scan_seg_q, scan_seg_d;
    logic [NUM_DIGITS-1:0]   scan_an_q, scan_an_d;

    // Per-digit blanking and post-blank segment values.
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   digit_blank;
    logic [6:0]              digit_seg [NUM_DIGITS];

    // Shadow capture; a held strobe simply recaptures each cycle.
    always_comb begin
        dig_d    = dig_q;
        lzb_d    = lzb_q;
        mask_d   = mask_q;
        loaded_d = loaded_q;
        if (iLOAD) begin
            dig_d    = iDIG;
            lzb_d    = iLZB;
            mask_d   = iBLINK_MASK;
            loaded_d = 1'b1;
        end
    end

    // Free-running scan and blink prescalers.
    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        blink_wrap = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));

        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        scan_idx_d = scan_idx_q;
        if (scan_wrap) begin
            if (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                scan_idx_d = '0;
            end else begin
                scan_idx_d = scan_idx_q + IDX_W'(1);
            end
        end

        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
    end

    // Leading-zero run from the top digit down; digit 0 always shows.
    always_comb begin
        logic zero_run;
        lz_blank = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run & (dig_q[4*k +: 4] == 4'h0);
            lz_blank[k] = lzb_q & zero_run;
        end
    end

    // Blank precedence: not loaded, then leading zero, then blink.
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit_blank[k] = ~loaded_q | lz_blank[k] | (~blink_phase_q & mask_q[k]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
            seg7_hex_decode u_dec (
                .iNIB   (dig_q[4*gi +: 4]),
                .iBLANK (digit_blank[gi]),
                .oSEG   (digit_seg[gi])
            );
        end
    endgenerate

    // Output staging; the scan bus follows the prescaler state it enters,
    // so slot cycle 0 is always a dark dead-time cycle.
    always_comb begin
        seg_d = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            seg_d[7*k +: 7] = digit_seg[k];
        end
        scan_seg_d = SEG_BLANK;
        scan_an_d  = '1;
        if (loaded_q && (scan_cnt_d != '0)) begin
            scan_an_d[scan_idx_d] = 1'b0;
            scan_seg_d            = digit_seg[scan_idx_d];
        end
    end

    // All state and output registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            dig_q         <= '0;
            lzb_q         <= 1'b0;
            mask_q        <= '0;
            loaded_q      <= 1'b0;
            scan_idx_q    <= '0;
            scan_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            seg_q         <= {NUM_DIGITS{SEG_BLANK}};
            scan_seg_q    <= SEG_BLANK;
            scan_an_q     <= '1;
        end else begin
            dig_q         <= dig_d;
            lzb_q         <= lzb_d;
            mask_q        <= mask_d;
            loaded_q      <= loaded_d;
            scan_idx_q    <= scan_idx_d;
            scan_cnt_q    <= scan_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            scan_seg_q    <= scan_seg_d;
            scan_an_q     <= scan_an_d;
        end
    end

    assign oSEG      = seg_q;
    assign oSCAN_SEG = scan_seg_q;
    assign oSCAN_AN  = scan_an_q;
    assign oLOADED   = loaded_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Bench for seg7_display_ctrl with 4 digits, 4-cycle scan slots and an
// 8-cycle blink half-period. A cycle-count reference model predicts every
// output at each falling edge.
module tb_seg7_display_ctrl;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BD = 8;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          load   = 1'b0;
    logic [15:0]   dig    = '0;
    logic          lzb    = 1'b0;
    logic [3:0]    mask   = '0;
    logic [27:0]   seg;
    logic [6:0]    scan_seg;
    logic [3:0]    scan_an;
    logic          loaded;

    int checks = 0;
    int errors = 0;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_display_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLINK_DIV  (BD)
    ) dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .iLOAD       (load),
        .iDIG        (dig),
        .iLZB        (lzb),
        .iBLINK_MASK (mask),
        .oSEG        (seg),
        .oSCAN_SEG   (scan_seg),
        .oSCAN_AN    (scan_an),
        .oLOADED     (loaded)
    );

    always #5 clk = ~clk;

    // Reference model: m_t counts clock edges since reset; m_* is the
    // shadow after those edges, p_* the shadow one edge earlier.
    int          m_t      = 0;
    logic [15:0] m_dig    = '0;
    logic        m_lzb    = 1'b0;
    logic [3:0]  m_mask   = '0;
    logic        m_loaded = 1'b0;
    logic [15:0] p_dig    = '0;
    logic        p_lzb    = 1'b0;
    logic [3:0]  p_mask   = '0;
    logic        p_loaded = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0;
            m_dig = '0; m_lzb = 1'b0; m_mask = '0; m_loaded = 1'b0;
            p_dig = '0; p_lzb = 1'b0; p_mask = '0; p_loaded = 1'b0;
        end else begin
            p_dig = m_dig; p_lzb = m_lzb; p_mask = m_mask; p_loaded = m_loaded;
            m_t = m_t + 1;
            if (load) begin
                m_dig = dig; m_lzb = lzb; m_mask = mask; m_loaded = 1'b1;
            end
        end
    end

    // Blink phase after t edges: visible for the first BD edges, then alternating.
    function automatic logic phase_at(int t);
        return ((t / BD) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [6:0] exp_digit(int k, logic [15:0] d, logic z, logic [3:0] m,
                                             logic ld, logic ph);
        logic all_zero;
        if (!ld) return 7'h7F;
        if (z && k > 0) begin
            all_zero = 1'b1;
            for (int j = k; j < ND; j++) begin
                if (d[4*j +: 4] != 4'h0) all_zero = 1'b0;
            end
            if (all_zero) return 7'h7F;
        end
        if (!ph && m[k]) return 7'h7F;
        return dec_tab[d[4*k +: 4]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    task automatic check_all();
        logic [27:0] e_seg;
        logic [6:0]  e_ss;
        logic [3:0]  e_an;
        logic        ph;
        int          cnt;
        int          idx;
        ph = (m_t == 0) ? 1'b1 : phase_at(m_t - 1);
        for (int k = 0; k < ND; k++) begin
            e_seg[7*k +: 7] = exp_digit(k, p_dig, p_lzb, p_mask, p_loaded, ph);
        end
        cnt = m_t % SD;
        idx = (m_t / SD) % ND;
        if (cnt == 0 || !p_loaded) begin
            e_an = 4'hF;
            e_ss = 7'h7F;
        end else begin
            e_an = ~(4'b0001 << idx);
            e_ss = e_seg[7*idx +: 7];
        end
        chk("oSEG", 32'(seg), 32'(e_seg));
        chk("oSCAN_SEG", 32'(scan_seg), 32'(e_ss));
        chk("oSCAN_AN", 32'(scan_an), 32'(e_an));
        chk("oLOADED", 32'(loaded), 32'(m_loaded));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic z, input logic [3:0] m);
        dig = d; lzb = z; mask = m; load = 1'b1;
        $display("load dig=%h lzb=%0d mask=%b", d, z, m);
        @(negedge clk);
        check_all();
        load = 1'b0;
    endtask

    function automatic logic [15:0] rand_dig();
        logic [15:0] r;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        end
        return r;
    endfunction

    initial begin
        // Reset state while held in reset.
        #12;
        check_all();
        chk("reset_seg", 32'(seg), 32'h0FFFFFFF);
        chk("reset_an", 32'(scan_an), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;

        // No load yet: everything stays dark.
        step(40);
        chk("unloaded_seg", 32'(seg), 32'h0FFFFFFF);
        chk("unloaded_loaded", 32'(loaded), 32'h0);

        // Plain decode, one cycle after capture.
        do_load(16'h12AF, 1'b0, 4'b0000);
        step(1);
        chk("dec_12AF", 32'(seg), 32'({7'h79, 7'h24, 7'h08, 7'h0E}));
        chk("loaded_set", 32'(loaded), 32'h1);

        // Leading-zero blanking, including the all-zero case.
        do_load(16'h0070, 1'b1, 4'b0000);
        step(1);
        chk("lzb_0070", 32'(seg), 32'({7'h7F, 7'h7F, 7'h78, 7'h40}));
        do_load(16'h0000, 1'b1, 4'b0000);
        step(1);
        chk("lzb_0000", 32'(seg), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

        // Scan sequence across several full frames.
        do_load(16'h8888, 1'b0, 4'b0000);
        step(40);

        // Blink on digit 1 over several half-periods.
        do_load(16'h5555, 1'b0, 4'b0010);
        step(40);

        // Randomised loads, including held strobes.
        for (int r = 0; r < 300; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                dig  = rand_dig();
                lzb  = 1'($urandom_range(0, 1));
                mask = 4'($urandom_range(0, 15));
                load = 1'b1;
                $display("load dig=%h lzb=%0d mask=%b", dig, lzb, mask);
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            check_all();
        end
        load = 1'b0;

        // Asynchronous reset in the middle of a slot and a blink half-period.
        do_load(16'h3C9D, 1'b0, 4'b1001);
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_all();
        chk("async_seg", 32'(seg), 32'h0FFFFFFF);
        chk("async_scan_seg", 32'(scan_seg), 32'h7F);
        chk("async_an", 32'(scan_an), 32'hF);
        chk("async_loaded", 32'(loaded), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(20);
        chk("post_reset_seg", 32'(seg), 32'h0FFFFFFF);

        // Recovery after a fresh load.
        do_load(16'hE4B6, 1'b0, 4'b0000);
        step(1);
        chk("recover_seg", 32'(seg), 32'({7'h06, 7'h19, 7'h03, 7'h02}));
        step(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
Parametrised hex-to-seven-segment display controller. It drives NUM_DIGITS digits in two output modes at once: static (one 7-bit bus per digit) and time-multiplexed scan (shared segment bus plus one-hot anode enables).
- Adds a load strobe with shadow register, leading-zero blanking, per-digit blink and anti-ghosting dead time.
- Sits between system status registers and the board 7-seg pins.

Parameters:
NUM_DIGITS, 8, number of digits; legal range 1..16.
SCAN_DIV, 50000, clock cycles each digit is enabled in scan mode; must be >= 2.
BLINK_DIV, 12500000, clock cycles per blink half-period; must be >= 2.

Ports:
iCLK  in  1  system clock.
iRST_N  in  1  asynchronous active-low reset.
iLOAD  in  1  one-cycle strobe; captures iDIG, iLZB and iBLINK_MASK.
iDIG  in  4*NUM_DIGITS  hex nibbles; digit k = iDIG[4k+3:4k]; digit 0 is least significant.
iLZB  in  1  leading-zero blanking enable.
iBLINK_MASK  in  NUM_DIGITS  bit k=1 makes digit k blink.
oSEG  out  7*NUM_DIGITS  static segments, active-low; digit k = oSEG[7k+6:7k]; bit0=a ... bit6=g.
oSCAN_SEG  out  7  scanned segment bus, active-low.
oSCAN_AN  out  NUM_DIGITS  scanned digit enables, one-hot active-low.
oLOADED  out  1  high once the first iLOAD has been taken since reset.

Behaviour:
- Reset (asynchronous, iRST_N=0):
  - Shadow data, LZB flag and mask are 0; oLOADED=0.
  - Every oSEG digit is 7'h7F; oSCAN_SEG=7'h7F; oSCAN_AN all ones.
  - Scan index and both prescalers are 0; blink phase is 1 (visible).
- Load:
  - iLOAD sampled high at edge N latches the shadow registers and sets oLOADED.
  - All outputs are registered, so new data appears on oSEG at edge N+1 (latency 1 cycle after capture).
  - iLOAD held high recaptures every cycle; the last capture wins. There is no other handshake.
- While oLOADED=0, all digits are blanked (7'h7F) regardless of inputs.
- Decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - Blank = 7F.
- Leading-zero blanking (shadow LZB=1):
  - Digits from NUM_DIGITS-1 downward are blanked while their value is 0, stopping at the first non-zero digit.
  - Digit 0 is never blanked by LZB, so all-zero data shows a single "0".
- Blink:
  - A prescaler counts 0..BLINK_DIV-1; at terminal count it wraps and toggles the blink phase.
  - While phase=0, digits with mask bit 1 are blanked. Phase=1 shows them.
  - A new iLOAD does not reset the phase.
- Blank precedence: not-loaded > LZB > blink > decode. The same post-blank value feeds both static and scan paths.
- Scan:
  - A prescaler counts 0..SCAN_DIV-1. At terminal count the index advances, wrapping NUM_DIGITS-1 -> 0.
  - Dead time: in prescaler cycle 0 of each slot, oSCAN_AN is all ones and oSCAN_SEG=7F.
  - In cycles 1..SCAN_DIV-1, oSCAN_AN[index]=0 and oSCAN_SEG shows digit[index].
- NUM_DIGITS=1: the index stays 0; dead time still applies.
- Simultaneous events:
  - iLOAD coinciding with a scan advance: the newly displayed slot shows the new data from the following edge.
  - A blink toggle coinciding with iLOAD is independent; both take effect.
- Reset mid-scan or mid-blink returns everything to the reset state immediately. No partial frame is required.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK = 7'h7F.
  - The 16-entry hex decode table as a function.
  - A clog2-based width helper for the index and prescalers.
- One combinational sub-module, seg7_hex_decode: nibble + blank in, 7-bit active-low out. It is instantiated NUM_DIGITS times via generate.
- Scan and blink prescalers and the LZB scan stay in the top module.

Test Plan:
Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=8.
1. Reset, then no load for 40 cycles -> oSEG=28'hFFFFFFF, oSCAN_AN stays 4'b1111, oLOADED=0.
2. iLOAD with iDIG=16'h12AF, LZB=0, mask=0 -> one cycle after capture, oSEG digits 3..0 = 79, 24, 08, 0E; oLOADED=1.
3. iDIG=16'h0070 with LZB=1 -> digits 3 and 2 = 7F, digit 1 = 78, digit 0 = 40. Then iDIG=0 -> only digit 0 = 40.
4. Scan with iDIG=16'h8888 -> per 4-cycle slot, oSCAN_AN = 1111, then 1110 x3; next slot 1111, then 1101 x3; ... wraps after 1011 and 0111. oSCAN_SEG=00 when enabled, 7F in dead cycles.
5. mask=4'b0010, iDIG=16'h5555 -> digit 1 alternates 12/7F every 8 cycles; digits 0, 2, 3 stay 12.
6. Assert iRST_N=0 mid-slot and mid-blink -> all outputs return to reset values asynchronously. After release, oSEG stays blanked until the next iLOAD.
